// File: rtl/mbu_init.sv
// mbu_init: bus initiator that programs the Memory Bank Unit MBx registers
// (MB0..MB7 at BASE_ADDR..BASE_ADDR+7) over the system I/O bus. It runs a
// preset of all eight registers after reset or on request, and also runs
// single-register OUT (write) and IN (read-back) cycles for the front panel.
// The bus lines are driven only while the block owns the bus.
module mbu_init #(
   parameter int unsigned STROBE_CLKS = 2,
   parameter logic [7:0]  BASE_ADDR   = 8'h08,
   parameter bit          AUTOSTART   = 1'b1
) (
   input  logic       clk4,
   input  logic       nreset,
   input  logic       nstart,
   input  logic [1:0] mode,
   input  logic [2:0] fp_sel,
   input  logic [7:0] fp_data,
   input  logic       nfpram_rom,
   input  logic       nbusgnt,
   output logic       nbusreq,
   inout  logic [7:0] ab,
   inout  logic [7:0] db,
   inout  logic       nsysdev,
   inout  logic       nr,
   inout  logic       nw,
   output logic [7:0] fp_q,
   output logic       busy,
   output logic       ndone
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [1:0] LP_MODE_PRESET = 2'd0;
   localparam logic [1:0] LP_MODE_READ   = 2'd2;
   localparam logic [1:0] LP_MODE_RSVD   = 2'd3;
   localparam logic [3:0] LP_STRB_LAST   = 4'(STROBE_CLKS - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_mode;
   logic [1:0] w_mode_nxt;
   logic [2:0] r_idx;
   logic [2:0] w_idx_nxt;
   logic [7:0] r_data;
   logic [7:0] w_data_nxt;
   logic [3:0] r_scnt;
   logic [3:0] w_scnt_nxt;
   logic       r_auto;
   logic       w_auto_nxt;
   logic [7:0] r_fp_q;

   logic       w_own;
   logic       w_write;
   logic       w_strobe;
   logic       w_last_strobe;
   logic [7:0] w_addr;

   // state and datapath registers; reset releases the bus immediately
   always_ff @(posedge clk4 or negedge nreset) begin
      if (!nreset) begin
         r_state <= S_IDLE;
         r_mode  <= '0;
         r_idx   <= '0;
         r_data  <= '0;
         r_scnt  <= '0;
         r_auto  <= AUTOSTART;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= w_mode_nxt;
         r_idx   <= w_idx_nxt;
         r_data  <= w_data_nxt;
         r_scnt  <= w_scnt_nxt;
         r_auto  <= w_auto_nxt;
      end
   end

   // next-state and operand latching
   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_idx_nxt   = r_idx;
      w_data_nxt  = r_data;
      w_scnt_nxt  = r_scnt;
      w_auto_nxt  = r_auto;
      case (r_state)
         S_IDLE: begin
            if (r_auto || !nstart) begin
               w_auto_nxt = 1'b0;
               // the power-up start is always a full preset
               w_mode_nxt = r_auto ? LP_MODE_PRESET : mode;
               if (w_mode_nxt == LP_MODE_PRESET) begin
                  w_idx_nxt  = '0;
                  w_data_nxt = nfpram_rom ? 8'h80 : 8'h00;
               end else begin
                  w_idx_nxt  = fp_sel;
                  w_data_nxt = fp_data;
               end
               w_state_nxt = (w_mode_nxt == LP_MODE_RSVD) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (!nbusgnt) w_state_nxt = S_SETUP;
         end
         S_SETUP: begin
            w_scnt_nxt  = '0;
            w_state_nxt = S_STROBE;
         end
         S_STROBE: begin
            if (w_last_strobe) w_state_nxt = S_HOLD;
            else               w_scnt_nxt  = r_scnt + 4'd1;
         end
         S_HOLD: begin
            if (r_mode == LP_MODE_PRESET && r_idx != 3'd7) begin
               w_idx_nxt   = r_idx + 3'd1;
               w_state_nxt = nbusgnt ? S_REQ : S_SETUP;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // bus ownership decode and status outputs
   always_comb begin
      w_own         = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);
      w_write       = (r_mode != LP_MODE_READ);
      w_strobe      = (r_state == S_STROBE);
      w_last_strobe = (r_scnt == LP_STRB_LAST);
      w_addr        = BASE_ADDR + {5'b0, r_idx};
      nbusreq       = !(w_own || (r_state == S_REQ));
      busy          = (r_state != S_IDLE);
      ndone         = (r_state != S_DONE);
      fp_q          = r_fp_q;
   end

   assign ab      = w_own ? w_addr : 'z;
   assign db      = (w_own && w_write) ? r_data : 'z;
   assign nsysdev = w_own ? 1'b0 : 1'bz;
   assign nw      = w_own ? !(w_strobe && w_write) : 1'bz;
   assign nr      = w_own ? !(w_strobe && !w_write) : 1'bz;

   // read-back capture on the final strobe edge of an IN cycle
   always_ff @(posedge clk4 or negedge nreset) begin
      if (!nreset) begin
         r_fp_q <= '0;
      end else if (w_strobe && !w_write && w_last_strobe) begin
         r_fp_q <= db;
      end
   end

endmodule

// File: tb/tb_mbu_init.sv
// tb_mbu_init: scoreboard bench for mbu_init. Stimulus pushes the expected
// bus cycles and completion pulses; a monitor reconstructs each bus cycle
// from the pins and compares it against the queue.
module tb_mbu_init;

   localparam int K_W = 0;
   localparam int K_R = 1;
   localparam int K_D = 2;

   typedef struct {
      int         kind;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic       clk4 = 1'b0;
   logic       nreset;
   logic       nstart;
   logic [1:0] mode;
   logic [2:0] fp_sel;
   logic [7:0] fp_data;
   logic       nfpram_rom;
   logic       nbusgnt;
   logic       nbusreq;
   wire  [7:0] ab;
   wire  [7:0] db;
   wire        nsysdev;
   wire        nr;
   wire        nw;
   logic [7:0] fp_q;
   logic       busy;
   logic       ndone;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t q[$];

   // released lines float high so hi-Z is observable
   pullup pu_ab (ab);
   pullup pu_db (db);
   pullup pu_sd (nsysdev);
   pullup pu_nr (nr);
   pullup pu_nw (nw);

   // memory bank model answers IN cycles with &A5
   assign db = (nsysdev == 1'b0 && nr == 1'b0) ? 8'hA5 : 8'hzz;

   always #5 clk4 = ~clk4;

   mbu_init #(.STROBE_CLKS(2), .BASE_ADDR(8'h08), .AUTOSTART(1'b1)) dut (
      .clk4(clk4), .nreset(nreset), .nstart(nstart), .mode(mode),
      .fp_sel(fp_sel), .fp_data(fp_data), .nfpram_rom(nfpram_rom),
      .nbusgnt(nbusgnt), .nbusreq(nbusreq), .ab(ab), .db(db),
      .nsysdev(nsysdev), .nr(nr), .nw(nw), .fp_q(fp_q), .busy(busy),
      .ndone(ndone)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input logic [7:0] addr, input logic [7:0] data);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      q.push_back(e);
   endtask

   task automatic push_preset(input logic [7:0] val, input int first, input int last);
      for (int i = first; i <= last; i++) push(K_W, 8'(8'h08 + i), val);
   endtask

   task automatic tick();
      @(negedge clk4);
      #1;
   endtask

   // waits for the ndone pulse, then checks the block went idle
   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (ndone !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      chk({name, "_done_seen"}, int'(ndone), 0);
      tick();
      chk({name, "_idle_busy"}, int'(busy), 0);
      chk({name, "_ndone_single"}, int'(ndone), 1);
   endtask

   task automatic pulse_start();
      nstart = 1'b0;
      tick();
      nstart = 1'b1;
   endtask

   // ---------------- monitor ----------------
   int         s_cnt = 0;
   logic       s_nw, s_nr, s_setup_ok, s_stable;
   logic [7:0] s_ab, s_db;
   logic       p_owned = 1'b0, p_strb_hi = 1'b1;
   logic [7:0] p_ab, p_db;

   always @(negedge clk4) begin
      exp_t e;
      cyc++;
      if (nreset == 1'b0) begin
         s_cnt   = 0;
         p_owned = 1'b0;
      end else begin
         if (nsysdev == 1'b0 && (nw == 1'b0 || nr == 1'b0)) begin
            if (s_cnt == 0) begin
               s_nw       = 1'b0;
               s_nr       = 1'b0;
               s_ab       = ab;
               s_db       = db;
               s_stable   = 1'b1;
               s_setup_ok = p_owned && p_strb_hi && (p_ab == ab) &&
                            ((nw == 1'b0) ? (p_db == db) : (p_db == 8'hFF));
            end else if (ab != s_ab || (nw == 1'b0 && db != s_db)) begin
               s_stable = 1'b0;
            end
            s_cnt++;
            if (nw == 1'b0) s_nw = 1'b1;
            if (nr == 1'b0) s_nr = 1'b1;
         end else if (s_cnt > 0) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_cycle: got ab=%h db=%h, no cycle expected", s_ab, s_db);
            end else begin
               e = q.pop_front();
               chk("cycle_kind", int'({s_nw, s_nr}), (e.kind == K_W) ? 2 : ((e.kind == K_R) ? 1 : 0));
               chk("cycle_addr", int'(s_ab), int'(e.addr));
               if (e.kind == K_W) chk("write_data", int'(s_db), int'(e.data));
               else               chk("read_fp_q", int'(fp_q), int'(e.data));
               chk("strobe_width", s_cnt, 2);
               chk("setup_phase", int'(s_setup_ok), 1);
               chk("strobe_stable", int'(s_stable), 1);
               chk("hold_phase", int'(nsysdev == 1'b0 && ab == s_ab && nw == 1'b1 && nr == 1'b1), 1);
            end
            s_cnt = 0;
         end
         if (ndone == 1'b0) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got ndone=0, no completion expected");
            end else begin
               e = q.pop_front();
               chk("done_order", e.kind, K_D);
               chk("done_nbusreq", int'(nbusreq), 1);
            end
         end
         p_owned   = (nsysdev == 1'b0);
         p_strb_hi = (nw == 1'b1 && nr == 1'b1);
         p_ab      = ab;
         p_db      = db;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int t0, n;
      nreset = 1'b1; nstart = 1'b1; mode = 2'd0; fp_sel = 3'd0;
      fp_data = 8'h00; nfpram_rom = 1'b1; nbusgnt = 1'b0;
      #1 nreset = 1'b0;
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_ndone", int'(ndone), 1);
      chk("rst_nbusreq", int'(nbusreq), 1);
      chk("rst_fp_q", int'(fp_q), 0);
      chk("rst_ab_hiz", int'(ab), 8'hFF);
      chk("rst_strobes_hiz", int'({nsysdev, nr, nw}), 7);
      tick();
      tick();

      // autostart preset, ROM setting, grant tied low
      push_preset(8'h80, 0, 7);
      push(K_D, 8'h00, 8'h00);
      nreset = 1'b1;
      n = 0;
      while (nsysdev !== 1'b0 && n < 20) begin tick(); n++; end
      chk("auto_first_setup", int'(nsysdev), 0);
      t0 = cyc;
      n = 0;
      while (ndone !== 1'b0 && n < 100) begin tick(); n++; end
      chk("preset_length", cyc - t0, 32);
      wait_done("auto");

      // write single: MB5 <= &3C
      mode = 2'd1; fp_sel = 3'd5; fp_data = 8'h3C;
      push(K_W, 8'h0D, 8'h3C);
      push(K_D, 8'h00, 8'h00);
      pulse_start();
      wait_done("wr1");

      // read single: MB2, model returns &A5
      mode = 2'd2; fp_sel = 3'd2; fp_data = 8'h11;
      push(K_R, 8'h0A, 8'hA5);
      push(K_D, 8'h00, 8'h00);
      pulse_start();
      wait_done("rd1");
      chk("rd1_fp_q_after", int'(fp_q), 8'hA5);

      // RAM preset with grant lost during MB3 strobe; ROM switch flips mid-run
      mode = 2'd0; nfpram_rom = 1'b0;
      push_preset(8'h00, 0, 7);
      push(K_D, 8'h00, 8'h00);
      pulse_start();
      n = 0;
      while (!(nw === 1'b0 && ab === 8'h0B) && n < 100) begin tick(); n++; end
      chk("mb3_strobe_seen", int'(ab), 8'h0B);
      nbusgnt = 1'b1;
      nfpram_rom = 1'b1;
      n = 0;
      while (nsysdev !== 1'b1 && n < 10) begin tick(); n++; end
      chk("gntloss_released", int'({nsysdev, nr, nw}), 7);
      chk("gntloss_ab_hiz", int'(ab), 8'hFF);
      chk("gntloss_db_hiz", int'(db), 8'hFF);
      chk("gntloss_nbusreq", int'(nbusreq), 0);
      repeat (3) tick();
      chk("gntloss_wait_nbusreq", int'(nbusreq), 0);
      chk("gntloss_wait_busy", int'(busy), 1);
      chk("gntloss_wait_idle_bus", int'(nsysdev), 1);
      nbusgnt = 1'b0;
      wait_done("gntloss");

      // reset during MB6 strobe, autostart reruns the whole preset
      push_preset(8'h80, 0, 5);
      pulse_start();
      n = 0;
      while (!(nw === 1'b0 && ab === 8'h0E) && n < 100) begin tick(); n++; end
      chk("mb6_strobe_seen", int'(ab), 8'h0E);
      @(posedge clk4);
      #2 nreset = 1'b0;
      #1;
      chk("midrst_ab_hiz", int'(ab), 8'hFF);
      chk("midrst_db_hiz", int'(db), 8'hFF);
      chk("midrst_strobes_hiz", int'({nsysdev, nr, nw}), 7);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_ndone", int'(ndone), 1);
      chk("midrst_nbusreq", int'(nbusreq), 1);
      chk("midrst_fp_q", int'(fp_q), 0);
      chk("midrst_queue", q.size(), 0);
      push_preset(8'h80, 0, 7);
      push(K_D, 8'h00, 8'h00);
      tick();
      nreset = 1'b1;
      wait_done("restart");

      // reserved mode: completion without any bus request
      mode = 2'd3;
      push(K_D, 8'h00, 8'h00);
      nstart = 1'b0;
      tick();
      chk("mode3_ndone", int'(ndone), 0);
      chk("mode3_nbusreq", int'(nbusreq), 1);
      nstart = 1'b1;
      tick();
      chk("mode3_ndone_end", int'(ndone), 1);
      chk("mode3_busy_end", int'(busy), 0);
      chk("mode3_nbusreq_end", int'(nbusreq), 1);

      repeat (3) tick();
      chk("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/mbu_init.md
# mbu_init

Bus initiator that programs the Memory Bank Unit's MBx registers over the system I/O bus. It issues OUT cycles to I/O addresses &008–&00F after reset or on front-panel request. It also performs single-register OUT (write) or IN (read-back) cycles for the front panel. It sits beside the front-panel controller and owns the AB/DB/nSYSDEV/nR/nW lines only while it holds a bus grant. Every MBx register must be written once after reset before any one is relied upon, because the register file powers up with random contents.

## Interface
- `STROBE_CLKS`, default 2: width of the nR/nW low pulse, in clocks; legal range 1–15.
- `BASE_ADDR`, default 8'h08: I/O address of MB0; MBn is at `BASE_ADDR + n`.
- `AUTOSTART`, default 1: when 1, a preset sequence starts automatically after reset release.

Ports:
- `clk4` in 1: sole clock; all state changes on the rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `nstart` in 1: active-low request, sampled each clock; ignored while `busy`=1.
- `mode` in 2: 0 = preset all, 1 = write single, 2 = read single, 3 = reserved.
- `fp_sel` in 3: register index for single modes.
- `fp_data` in 8: data for write single.
- `nfpram_rom` in 1: RAM/ROM switch, high = ROM.
- `nbusgnt` in 1: active-low bus grant.
- `nbusreq` out 1: active-low bus request.
- `ab` inout 8: address bus, driven only when owned.
- `db` inout 8: data bus, driven only on owned write cycles.
- `nsysdev` inout 1: system-device select, driven only when owned.
- `nr` inout 1: read strobe, driven only when owned.
- `nw` inout 1: write strobe, driven only when owned.
- `fp_q` out 8: last value read back.
- `busy` out 1: sequence in progress.
- `ndone` out 1: one-clock active-low completion pulse.

## Operation
- FSM states: IDLE, REQ, SETUP, STROBE, HOLD, DONE.
- IDLE
  - On `nstart`=0 (or the first edge after reset when `AUTOSTART`=1), latch `mode`, `fp_sel` and `fp_data`.
  - Latch preset value: &80 if `nfpram_rom`=1, else &00.
  - For preset, clear the index counter; for single modes, load it from `fp_sel`.
  - Go to REQ.
  - Mode 3 goes directly to DONE with no bus activity.
- REQ: `nbusreq`=0. On `nbusgnt`=0, go to SETUP.
- SETUP, 1 clock
  - Drive `ab`=`BASE_ADDR`+index and `nsysdev`=0; `nr` and `nw` are driven high.
  - On writes, drive `db` with the preset value or `fp_data`.
- STROBE, `STROBE_CLKS` clocks: `nw`=0 for writes, or `nr`=0 for reads. On reads, `fp_q` captures `db` at the final STROBE edge.
- HOLD, 1 clock: strobes high; `ab`, `db` and `nsysdev` still driven.
- After HOLD:
  - Preset with index < 7 and grant still held: increment index, go to SETUP.
  - Preset with index < 7 and grant lost: increment index, release the bus, go to REQ.
  - Otherwise go to DONE.
- DONE, 1 clock: release the bus, `nbusreq`=1, `ndone`=0, `busy`=0 on exit. Then go to IDLE.
- `busy`=1 in every state except IDLE.
- Index counter is 3 bits; preset ends after index 7 and never wraps to 0.

## Timing
- Reset values: bus outputs hi-Z, `nbusreq`=1, `busy`=0, `ndone`=1, `fp_q`=&00, state IDLE.
- Reset is asynchronous: asserting `nreset` mid-cycle releases every bus line immediately. No partial write is retried; the next start reruns the whole operation.
- Grant to first SETUP: 1 clock.
- Each bus cycle lasts 2+`STROBE_CLKS` clocks, i.e. 4 by default.
- A preset with an uninterrupted grant takes 32 clocks from SETUP of MB0 to the end of HOLD of MB7. `ndone` follows 1 clock later.
- Address and data are stable from SETUP through HOLD, giving at least one clock of setup and one of hold around the strobe.
- `nbusgnt` deasserted during SETUP, STROBE or HOLD: finish the current cycle, then re-request. No cycle is truncated or repeated.
- `nstart` held low across DONE→IDLE starts a new operation on the next edge. This is legal, and the front panel must debounce.
- `nfpram_rom` changing mid-preset has no effect; the value latched at start is used.

## Test plan
- Reset release, `AUTOSTART`=1, `nfpram_rom`=1, grant tied low: 8 OUT cycles to &08..&0F, each writing &80, 4 clocks apiece. `ndone` pulses once; `busy` returns to 0.
- `nstart` pulse, `mode`=1, `fp_sel`=5, `fp_data`=&3C: one cycle with `ab`=&0D, `db`=&3C, `nw` low for 2 clocks. `nr` stays high.
- `mode`=2, `fp_sel`=2, bench model returns &A5 on `db` while `nr`=0: `fp_q`=&A5 after the cycle; `db` is never driven by the block.
- Preset with `nbusgnt` deasserted during STROBE of MB3: MB3's cycle completes and the bus goes hi-Z. `nbusreq` stays 0; on regrant, MB4..MB7 follow with no duplicate writes.
- `nreset` pulsed during STROBE of MB6: all bus lines go hi-Z within the same clock, and `busy`/`ndone` take their reset values. With `AUTOSTART`=1 the sequence restarts at MB0.
- `mode`=3 start: `ndone` pulses 1 clock after start, with `nbusreq` never asserted.
